// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use detection, 2-bit branch predictor,
// EX-stage branch resolution and PC redirect. Optional perf counters under PIPE_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter logic [1:0] PRED_INIT = 2'b11
`ifdef PIPE_PERF_CNT_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_branch_i,
  input  logic        ex_memread_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_branch_i,
  input  logic        ex_predict_i,
  input  logic        ex_taken_i,
  input  logic [31:0] ex_T_pc_i,
  input  logic [31:0] ex_NT_pc_i,
  input  logic        mem_stall_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic        idex_flush_o,
  output logic        predict_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o
`ifdef PIPE_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] branch_cnt_o
`endif
);

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } pred_state_e;

  pred_state_e state_q, state_d;
  logic        mispredict;
  logic        load_use;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= pred_state_e'(PRED_INIT);
    else        state_q <= state_d;
  end

  always_comb begin
    mispredict    = ex_branch_i & (ex_predict_i != ex_taken_i);
    load_use      = ex_memread_i & (ex_rd_i != 5'd0) &
                    ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));
    state_d       = state_q;
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = ex_NT_pc_i;
    predict_o     = id_branch_i & state_q[1];

    if (ex_branch_i && !mem_stall_i) begin
      unique case (state_q)
        SNT: state_d = ex_taken_i ? WNT : SNT;
        WNT: state_d = ex_taken_i ? WT  : SNT;
        WT:  state_d = ex_taken_i ? ST  : WNT;
        ST:  state_d = ex_taken_i ? ST  : WT;
        default: state_d = state_q;
      endcase
    end

    if (mem_stall_i) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
    end else if (mispredict) begin
      // The ID instruction is squashed, so a coincident load-use hazard is moot.
      redirect_o    = 1'b1;
      redirect_pc_o = ex_taken_i ? ex_T_pc_i : ex_NT_pc_i;
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
    end else if (load_use) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      idex_flush_o = 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o  <= '0;
      flush_cnt_o  <= '0;
      branch_cnt_o <= '0;
    end else if (!mem_stall_i) begin
      if (!mispredict && load_use) stall_cnt_o <= stall_cnt_o + CNT_ONE;
      if (mispredict)              flush_cnt_o <= flush_cnt_o + CNT_ONE;
      if (ex_branch_i)             branch_cnt_o <= branch_cnt_o + CNT_ONE;
    end
  end
`endif

endmodule
